adc_frame_deserializer: RTL and testbench
=========================================

// Module: adc_frame_deserializer
// PURPOSE
//  Consumes the single-ended serial ADC data and frame lines produced by the LVDS input
//  buffers in main_ADC and rebuilds parallel sample words. Word boundaries come from
//  rising edges of the frame line. Tracks frame alignment (IDLE/SEARCH/LOCKED) and counts
//  framing errors. Optional training-pattern check for link bring-up. SDR, 1 bit per clk.
// PARAMETERS
//  WORD_W        12       bits per ADC sample word, MSB first on the wire (>=4)
//  LOCK_FRAMES   4        consecutive on-time frame edges needed to declare lock (>=1)
//  ERR_W         16       width of saturating framing-error counter
//  TRAIN_PATTERN 12'hF0C  expected word when train_en=1 (WORD_W bits wide)
// PORTS
//  clk          in   1        bit clock; all logic on rising edge
//  rst          in   1        asynchronous, active-high reset
//  din          in   1        serial data from diff_to_single_ended output
//  frame        in   1        frame marker from diff_to_single_ended output
//  clr_err      in   1        sync pulse: clear err_cnt
//  train_en     in   1        compare each emitted word against TRAIN_PATTERN
//  data_out     out  WORD_W   last complete word, MSB = first bit received
//  data_valid   out  1        1-cycle pulse, data_out updated this cycle
//  locked       out  1        high in LOCKED state
//  err_cnt      out  ERR_W    framing errors since reset/clear, saturates at all-ones
//  pattern_err  out  1        1-cycle pulse with data_valid when train_en & word!=pattern
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, bit_idx=0, good_cnt=0, shift reg and input regs 0.
//  - Input stage: din_q<=din, frame_q<=frame, frame_q1<=frame_q. edge = frame_q & ~frame_q1.
//    The din_q bit in the edge cycle is word bit WORD_W-1 (bit_idx=0).
//  - Each cycle outside IDLE: sr<={sr[WORD_W-2:0],din_q}; bit_idx increments, wraps
//    WORD_W-1 -> 0. A wrap cycle is one where bit_idx==WORD_W-1.
//  - Word emit: in the wrap cycle, the next clk registers data_out={sr[WORD_W-2:0],din_q},
//    data_valid=1. Latency: LSB at din pin in cycle t -> data_valid in cycle t+2.
//  - Edge classification (outside IDLE): on-time = edge in the cycle after a wrap cycle
//    (bit_idx==0). Misaligned = edge at any other bit_idx. Missing = no edge at bit_idx==0.
//  - FSM:
//    IDLE:   no words emitted; edge -> SEARCH, bit_idx=0 (edge bit captured), good_cnt=0.
//    SEARCH: on-time edge -> good_cnt++; good_cnt reaching LOCK_FRAMES -> LOCKED.
//            Misaligned/missing -> stay SEARCH, good_cnt=0, err_cnt++.
//    LOCKED: on-time edge -> stay. Misaligned/missing -> SEARCH, good_cnt=0, err_cnt++.
//  - Misaligned edge: partial word discarded (no data_valid); bit_idx restarts at 0 with
//    the edge bit as MSB. Missing edge: the completed word was already emitted; counting
//    continues free-running.
//  - Words are emitted in SEARCH and LOCKED. Consumers qualify them with locked.
//  - err_cnt saturates at 2^ERR_W-1. clr_err and error in the same cycle -> err_cnt=0
//    (clear wins).
//  - pattern_err: registered alongside data_valid; train_en is sampled in the wrap cycle.
//  - rst asserted mid-word: immediate return to reset state; partial word lost, no
//    data_valid on release.
// TESTING (WORD_W=12, LOCK_FRAMES=4, ERR_W=16)
//  1 Reset, then frame edges every 12 clk with words 0xA5C,0x123,... -> data_valid every
//    12 clk, exact words 2 clk after each LSB, locked rises after the 4th on-time edge.
//  2 When locked, inject one edge 5 bits early -> partial word dropped, err_cnt=1,
//    locked=0, resync on the new edge, relock after 4 on-time edges.
//  3 When locked, suppress one frame edge -> the word is still emitted, err_cnt+1,
//    locked=0, free-running words continue.
//  4 Force err_cnt to 0xFFFE, inject 3 errors -> holds 0xFFFF. Pulse clr_err coincident
//    with an error -> 0.
//  5 train_en=1, send 0xF0C then 0xF0D -> pattern_err=0 then exactly one pulse.
//  6 Assert rst at bit 6 of a word, release, restart framing -> no spurious data_valid,
//    state IDLE until the first edge, outputs 0 during reset.

Source files
------------

// File: rtl/adc_frame_deserializer.sv
// Serial-to-parallel ADC word rebuilder: frame-edge alignment tracking (IDLE/SEARCH/LOCKED),
// saturating framing-error counter and optional training-pattern check.
//
// state    | meaning
// S_IDLE   | waiting for the first frame edge, no words emitted
// S_SEARCH | framing, counting consecutive on-time edges toward lock
// S_LOCKED | LOCK_FRAMES on-time edges seen, word boundaries trusted
module adc_frame_deserializer #(
  parameter int                WORD_W        = 12,
  parameter int                LOCK_FRAMES   = 4,
  parameter int                ERR_W         = 16,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = 12'hF0C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              frame,
  input  logic              clr_err,
  input  logic              train_en,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              pattern_err
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int GC_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LOCKED} state_t;

  state_t            state, state_nxt;
  logic              din_q, frame_q, frame_q1;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [GC_W-1:0]   good_cnt, good_cnt_nxt;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] word;
  logic              frame_edge, at_zero, active;
  logic              on_time, mis_edge, miss_edge, frame_err, emit, shift_en;

  assign frame_edge = frame_q & ~frame_q1;
  assign active     = (state != S_IDLE);
  assign at_zero    = (bit_idx == '0);
  assign on_time    = active & frame_edge & at_zero;
  assign mis_edge   = active & frame_edge & ~at_zero;
  assign miss_edge  = active & ~frame_edge & at_zero;
  assign frame_err  = mis_edge | miss_edge;
  // A misaligned edge in the last bit slot still starts a new word, so nothing is emitted.
  assign emit       = active & ~mis_edge & (bit_idx == IDX_LAST);
  assign shift_en   = active | frame_edge;
  assign word       = {sr[WORD_W-2:0], din_q};

  always_comb begin
    bit_idx_nxt = bit_idx;
    if (!active && !frame_edge)
      bit_idx_nxt = '0;
    else if (frame_edge && (!active || !at_zero))
      bit_idx_nxt = IDX_W'(1);
    else if (bit_idx == IDX_LAST)
      bit_idx_nxt = '0;
    else
      bit_idx_nxt = bit_idx + IDX_W'(1);
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    case (state)
      S_IDLE: begin
        if (frame_edge) begin
          state_nxt    = S_SEARCH;
          good_cnt_nxt = '0;
        end
      end
      S_SEARCH: begin
        if (frame_err) begin
          good_cnt_nxt = '0;
        end else if (on_time) begin
          if (good_cnt == GC_LAST) state_nxt = S_LOCKED;
          good_cnt_nxt = good_cnt + GC_W'(1);
        end
      end
      S_LOCKED: begin
        if (frame_err) begin
          state_nxt    = S_SEARCH;
          good_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        good_cnt_nxt = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked = (state == S_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q       <= 1'b0;
      frame_q     <= 1'b0;
      frame_q1    <= 1'b0;
      bit_idx     <= '0;
      sr          <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      pattern_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      din_q       <= din;
      frame_q     <= frame;
      frame_q1    <= frame_q;
      bit_idx     <= bit_idx_nxt;
      if (shift_en) sr <= word;
      data_valid  <= emit;
      pattern_err <= emit & train_en & (word != TRAIN_PATTERN);
      if (emit) data_out <= word;
      if (clr_err)
        err_cnt <= '0;
      else if (frame_err && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_frame_deserializer.sv
// Scoreboard bench for adc_frame_deserializer: framing, lock, error counting, training check.
module tb_adc_frame_deserializer;

  localparam logic [11:0] PATTERN = 12'hF0C;

  logic        clk = 1'b0;
  logic        rst, din, frame, clr_err, train_en;
  logic [11:0] data_out, data_out_s;
  logic        data_valid, locked, pattern_err;
  logic        dv_s, locked_s, perr_s;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt_s;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [11:0] w;
    logic        pe;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  adc_frame_deserializer u_dut (
    .clk(clk), .rst(rst), .din(din), .frame(frame), .clr_err(clr_err), .train_en(train_en),
    .data_out(data_out), .data_valid(data_valid), .locked(locked), .err_cnt(err_cnt),
    .pattern_err(pattern_err)
  );

  // Narrow error counter instance so saturation is reachable in a short run.
  adc_frame_deserializer #(.ERR_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .din(din), .frame(frame), .clr_err(clr_err), .train_en(train_en),
    .data_out(data_out_s), .data_valid(dv_s), .locked(locked_s), .err_cnt(err_cnt_s),
    .pattern_err(perr_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive nb bits of w MSB first; frame high for the first half of the word when fr=1.
  task automatic send_word(input logic [11:0] w, input bit fr, input bit push,
                           input bit clr, input bit tr, input int nb = 12);
    logic [11:0] wv;
    wv = w;
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      din   = wv[11-i];
      frame = fr && (i < 6);
      if (i == 1) clr_err = clr;
      if (i == 2) clr_err = 1'b0;
      if (i == 3) train_en = tr;
      if (i == 11 && push) sb.push_back('{wv, tr && (wv != PATTERN), cyc + 2});
    end
  endtask

  task automatic chk_lock(input string tag, input logic exp);
    chk(tag, locked, exp);
    chk({tag, "_sat"}, locked_s, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},   data_out,    0);
    chk({tag, "_valid"},  data_valid,  0);
    chk({tag, "_locked"}, locked,      0);
    chk({tag, "_err"},    err_cnt,     0);
    chk({tag, "_perr"},   pattern_err, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", data_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.w);
          chk("pattern_err", pattern_err, e.pe);
          chk("latency", cyc, e.cyc);
          chk("sat_valid", dv_s, 1);
          chk("sat_data", data_out_s, e.w);
        end
      end else if (pattern_err) begin
        chk("perr_no_valid", pattern_err, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] words [8];
    words = '{12'hA5C, 12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h0F0, 12'hF0F};
    rst = 1'b1; din = 1'b0; frame = 1'b0; clr_err = 1'b0; train_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Clean framing and initial lock
    for (int k = 0; k < 8; k++) begin
      send_word(words[k], 1, 1, 0, 0);
      if (k == 3) chk_lock("lock_before_4th", 0);
      if (k == 4) chk_lock("lock_after_4th", 1);
    end
    chk("err_clean", err_cnt, 0);

    // Edge 5 bits early: partial word dropped, resync and relock
    send_word(12'h3C3, 1, 0, 0, 0, 7);
    for (int k = 0; k < 5; k++) begin
      send_word(12'h100 + 12'(k), 1, 1, 0, 0);
      if (k == 0) begin
        chk("err_misaligned", err_cnt, 1);
        chk("err_misaligned_sat", err_cnt_s, 1);
        chk_lock("unlock_misaligned", 0);
      end
      if (k == 3) chk_lock("relock_early", 0);
      if (k == 4) chk_lock("relock", 1);
    end

    // Missing edge: word still emitted, free-running count continues
    send_word(12'h2AA, 0, 1, 0, 0);
    chk("err_missing", err_cnt, 2);
    chk_lock("unlock_missing", 0);
    for (int k = 0; k < 4; k++) begin
      send_word(12'h200 + 12'(k), 1, 1, 0, 0);
      if (k == 2) chk_lock("relock_missing_early", 0);
      if (k == 3) chk_lock("relock_missing", 1);
    end

    // Saturation and clear-wins
    for (int k = 0; k < 3; k++) send_word(12'h300 + 12'(k), 0, 1, 0, 0);
    chk("err_count_5", err_cnt, 5);
    chk("err_saturated", err_cnt_s, 3);
    send_word(12'h3FF, 0, 1, 1, 0);
    chk("err_clear_wins", err_cnt, 0);
    chk("err_clear_wins_sat", err_cnt_s, 0);
    for (int k = 0; k < 5; k++) send_word(12'h400 + 12'(k), 1, 1, 0, 0);
    chk_lock("relock_after_clear", 1);

    // Training pattern check
    send_word(PATTERN, 1, 1, 0, 1);
    send_word(12'hF0D, 1, 1, 0, 1);
    send_word(12'h555, 1, 1, 0, 0);
    send_word(12'h0F0, 1, 1, 0, 0);

    // Reset mid-word
    send_word(12'h777, 1, 0, 0, 0, 7);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midword_reset");
    repeat (3) @(posedge clk);
    #1;
    frame = 1'b0;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      din = 1'($urandom_range(0, 1));
    end
    chk("idle_locked", locked, 0);
    chk("idle_err", err_cnt, 0);
    chk("idle_data", data_out, 0);
    for (int k = 0; k < 6; k++) begin
      send_word(12'h500 + 12'(k * 17), 1, 1, 0, 0);
      if (k == 3) chk_lock("post_reset_lock_early", 0);
      if (k == 4) chk_lock("post_reset_lock", 1);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
